mem_burst_master: RTL
=====================

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter XLEN, 64, memory port data/address width.
REQ-002 SHALL have parameter BEATS, 4, beats per line transfer (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  line request offered.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_addr  input  XLEN  byte address; bits [log2(BEATS*8)-1:0] ignored.
REQ-008 SHALL have port req_wen  input  1  1 = line write, 0 = line read.
REQ-009 SHALL have port req_wdata  input  BEATS*XLEN  write line; beat k in bits [k*XLEN +: XLEN].
REQ-010 SHALL have port req_wmask  input  BEATS*XLEN  per-bit write mask, same beat layout.
REQ-011 SHALL have port resp_valid  output  1  response held for consumer.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  BEATS*XLEN  read line, beat layout as req_wdata; zero for writes.
REQ-014 SHALL have port resp_wen  output  1  echo of req_wen of the completed request.
REQ-015 SHALL have ports mem_raddr, mem_waddr, mem_wdata, mem_wmask  output  XLEN each  memory-side read/write beat signals.
REQ-016 SHALL have port mem_rdata  input  XLEN  memory read data, valid one cycle after mem_raddr is sampled.
REQ-017 SHALL have port mem_wen  output  1  memory write enable, one beat per cycle.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = (state == IDLE).
REQ-019 On req_valid && req_ready, SHALL latch line base (address with low bits cleared), wen, wdata, wmask; go to WRITE if req_wen else READ; beat counter cnt = 0.
REQ-020 In WRITE, SHALL drive mem_wen = 1, mem_waddr = base + cnt*8, mem_wdata/mem_wmask = beat cnt; cnt increments each cycle; after beat BEATS-1 go to RESP.
REQ-021 In READ, for cnt < BEATS SHALL drive mem_raddr = base + cnt*8; for cnt >= 1 SHALL capture mem_rdata into beat cnt-1; cnt runs 0..BEATS, then go to RESP.
REQ-022 Read response SHALL assert resp_valid BEATS+2 cycles after the accept cycle (6 for BEATS=4); write response BEATS+1 cycles after (5).
REQ-023 In RESP, resp_valid = 1 and resp_rdata/resp_wen SHALL stay stable until resp_ready; on handshake go to IDLE; next request accepted no earlier than the following cycle.
REQ-024 Outside WRITE, mem_wen SHALL be 0; outside READ beat-issue cycles, mem_raddr SHALL be 0; mem_waddr/mem_wdata/mem_wmask SHALL be 0 when mem_wen = 0.
REQ-025 Beat addresses SHALL stay within the aligned line; base + cnt*8 SHALL never carry out of the line-offset bits.
REQ-026 Request inputs SHALL be ignored outside IDLE; resp_ready SHALL be ignored outside RESP.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, cnt 0, resp_valid 0, mem_wen 0, all mem_* address/data outputs 0, resp_rdata 0, resp_wen 0.
REQ-028 Reset mid-READ or mid-WRITE SHALL abort without response; writes already issued are not rolled back; req_ready is 1 from the first cycle after rst_n rises.

Structure
REQ-029 XLEN, BEATS, derived LINE_BYTES/offset width and the state enum SHALL live in shared package mem_pkg.
REQ-030 Block SHALL be flat; no sub-module.

Verification
REQ-031 Read 0x8000_0010 with memory word at A = A^0xAAAA -> beats from 0x8000_0000..0x8000_0018 returned, resp_valid in cycle 6 after accept.
REQ-032 Write 0x8000_0020, wdata beats 1,2,3,4, mask all-ones on beats 0,2 and zero on 1,3 -> four mem_wen cycles, addresses 0x..20..0x..38, resp_valid in cycle 5, readback shows only beats 0,2 changed.
REQ-033 resp_ready held low 10 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout, no mem_wen.
REQ-034 rst_n pulsed low during write beat 2 -> mem_wen 0 in same cycle, no resp_valid, next request completes normally.
REQ-035 Back-to-back requests with resp_ready tied high -> each accepted one cycle after the previous response handshake; read-after-write to same line returns written data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, line geometry and FSM states for the line-burst memory master.
package mem_pkg;

    localparam int XLEN       = 64;
    localparam int BEATS      = 4;
    localparam int LINE_BYTES = BEATS * 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Each beat occupies 8 bytes of address space regardless of XLEN.
    function automatic int offset_width(input int beats);
        return $clog2(beats * 8);
    endfunction

endpackage

// File: rtl/mem_burst_master.sv
// Turns one line request into BEATS single-beat memory accesses, then holds
// the assembled response until the consumer takes it.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int XLEN  = mem_pkg::XLEN,
    parameter int BEATS = mem_pkg::BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XLEN-1:0]       req_addr,
    input  logic                  req_wen,
    input  logic [BEATS*XLEN-1:0] req_wdata,
    input  logic [BEATS*XLEN-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BEATS*XLEN-1:0] resp_rdata,
    output logic                  resp_wen,
    output logic [XLEN-1:0]       mem_raddr,
    output logic [XLEN-1:0]       mem_waddr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN-1:0]       mem_wmask,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  mem_wen
);

    localparam int OFF_W = offset_width(BEATS);
    localparam int BW    = OFF_W - 3;
    localparam int CW    = $clog2(BEATS + 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [XLEN-OFF_W-1:0]   line_q, line_d;
    logic                    wen_q, wen_d;
    logic [BEATS*XLEN-1:0]   wdata_q, wdata_d;
    logic [BEATS*XLEN-1:0]   wmask_q, wmask_d;
    logic [BEATS*XLEN-1:0]   rdata_q, rdata_d;

    logic [BW-1:0]           beat_idx;
    logic [BW-1:0]           cap_idx;
    logic [XLEN-1:0]         beat_addr;

    assign beat_idx  = cnt_q[BW-1:0];
    assign cap_idx   = BW'(cnt_q - CW'(1));
    // Offset is concatenated, not added, so a beat can never leave its line.
    assign beat_addr = {line_q, beat_idx, 3'b000};

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: every variable gets a hold default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    line_d  = req_addr[XLEN-1:OFF_W];
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = req_wen ? WRITE : READ;
                end
            end
            WRITE: begin
                if (cnt_q == CW'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            READ: begin
                // Memory answers one cycle late, so beat cnt-1 arrives now.
                if (cnt_q != '0) begin
                    rdata_d[cap_idx*XLEN +: XLEN] = mem_rdata;
                end
                if (cnt_q == CW'(BEATS)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_wen   = wen_q;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        mem_raddr  = '0;
        unique case (state_q)
            WRITE: begin
                mem_wen   = 1'b1;
                mem_waddr = beat_addr;
                mem_wdata = wdata_q[beat_idx*XLEN +: XLEN];
                mem_wmask = wmask_q[beat_idx*XLEN +: XLEN];
            end
            READ: begin
                if (cnt_q < CW'(BEATS)) begin
                    mem_raddr = beat_addr;
                end
            end
            default: ;
        endcase
    end

endmodule
